acc_diff_decoder: RTL and testbench

ACC_DIFF_DECODER -- requirements
Module: acc_diff_decoder

---
 rtl/acc_diff_decoder.sv | 109 ++++++++++
 tb/tb_acc_diff_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_diff_decoder.sv
// Running-sum difference decoder feeding a 2-entry output FIFO.
// Optional per-word wrap flag on OutWrap when ACC_DIFF_WRAP_EN is defined.
module acc_diff_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InSum,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Sync,
    output logic [WIDTH-1:0] OutData,
    output logic             OutValid,
    input  logic             OutReady,
`ifdef ACC_DIFF_WRAP_EN
    output logic             OutWrap,
`endif
    output logic [1:0]       Level
);

`ifdef ACC_DIFF_WRAP_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    mem0;
    logic [EW-1:0]    mem1;
    logic             push;
    logic             pop;

    assign push = InValid & InReady;
    assign pop  = OutValid & OutReady;
    assign base = Sync ? '0 : prev;
    assign word = InSum - base;

`ifdef ACC_DIFF_WRAP_EN
    assign entry   = {(!Sync && (InSum < prev)), word};
    assign OutWrap = mem0[WIDTH];
`else
    assign entry = word;
`endif
    assign OutData = mem0[WIDTH-1:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop) state_nxt = FULL;
                else if (!push && pop) state_nxt = EMPTY;
            end
            FULL: if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags depend on registered state only.
    always_comb begin
        InReady  = (state != FULL);
        OutValid = (state != EMPTY);
        Level    = state;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev <= '0;
            mem0 <= '0;
            mem1 <= '0;
        end else begin
            if (push) begin
                prev <= InSum;
            end else if (Sync) begin
                prev <= '0;
            end
            // Head is mem0; a push lands in mem0 when it is free or leaving.
            if (push) begin
                if (state == EMPTY || pop) begin
                    mem0 <= entry;
                end else begin
                    mem1 <= entry;
                end
            end else if (pop && state == FULL) begin
                mem0 <= mem1;
            end
        end
    end

endmodule

// File: tb/tb_acc_diff_decoder.sv
// Scoreboard bench for acc_diff_decoder: directed sums with hand-computed
// expected words, checked by a monitor as the DUT presents them.
module tb_acc_diff_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] InSum = '0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic       Sync = 1'b0;
    logic [3:0] OutData;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic [1:0] Level;
`ifdef ACC_DIFF_WRAP_EN
    logic       OutWrap;
`endif

    typedef struct {
        logic [3:0] d;
        logic       w;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic acc;

    acc_diff_decoder #(.WIDTH(4)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .InSum(InSum),
        .InValid(InValid),
        .InReady(InReady),
        .Sync(Sync),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
`ifdef ACC_DIFF_WRAP_EN
        .OutWrap(OutWrap),
`endif
        .Level(Level)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Offer one sum for a cycle; expectation queued only if it is taken.
    task automatic send(input logic [3:0] sum, input logic sy,
                        input logic [3:0] exp_d, input logic exp_w,
                        output logic taken);
        exp_t e;
        InSum   = sum;
        Sync    = sy;
        InValid = 1'b1;
        taken   = InReady;
        if (taken) begin
            e.d = exp_d;
            e.w = exp_w;
            q.push_back(e);
        end
        cyc();
        InValid = 1'b0;
        Sync    = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Reset && OutValid && OutReady) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word actual=%0d required=none",
                             OutData);
                end else begin
                    e = q.pop_front();
                    check("out_data", OutData, e.d);
`ifdef ACC_DIFF_WRAP_EN
                    check("out_wrap", OutWrap, e.w);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("rst_level", Level, 0);
        check("rst_valid", OutValid, 0);
        check("rst_ready", InReady, 1);
        check("rst_data", OutData, 0);
`ifdef ACC_DIFF_WRAP_EN
        check("rst_wrap", OutWrap, 0);
`endif
        #10;
        Reset = 1'b1;
        #1;
        OutReady = 1'b1;

        // basic decode: 3,7,7,12 -> 3,4,0,5
        send(4'd3, 1'b0, 4'd3, 1'b0, acc);
        check("lat_valid", OutValid, 1);
        check("lat_data", OutData, 3);
        check("basic_lvl0", Level, 1);
        send(4'd7, 1'b0, 4'd4, 1'b0, acc);
        check("basic_lvl1", Level, 1);
        send(4'd7, 1'b0, 4'd0, 1'b0, acc);
        check("basic_lvl2", Level, 1);
        send(4'd12, 1'b0, 4'd5, 1'b0, acc);
        check("basic_lvl3", Level, 1);
        cyc();
        check("basic_drain", Level, 0);

        // wrap: prev 14, sum 2 -> 4 with wrap
        send(4'd14, 1'b0, 4'd2, 1'b0, acc);
        send(4'd2, 1'b0, 4'd4, 1'b1, acc);
        cyc();

        // backpressure
        OutReady = 1'b0;
        Sync = 1'b1;
        cyc();
        Sync = 1'b0;
        send(4'd1, 1'b0, 4'd1, 1'b0, acc);
        check("bp_acc1", acc, 1);
        send(4'd3, 1'b0, 4'd2, 1'b0, acc);
        check("bp_acc2", acc, 1);
        send(4'd6, 1'b0, 4'd3, 1'b0, acc);
        check("bp_refused", acc, 0);
        check("bp_level", Level, 2);
        check("bp_inready", InReady, 0);
        OutReady = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            send(4'd6, 1'b0, 4'd3, 1'b0, acc);
        end
        check("bp_retry", acc, 1);
        cyc();
        check("bp_drain", Level, 0);

        // simultaneous push and pop at ONE
        OutReady = 1'b0;
        send(4'd7, 1'b0, 4'd1, 1'b0, acc);
        check("pp_start", Level, 1);
        OutReady = 1'b1;
        send(4'd8, 1'b0, 4'd1, 1'b0, acc);
        check("pp_lvl0", Level, 1);
        send(4'd10, 1'b0, 4'd2, 1'b0, acc);
        check("pp_lvl1", Level, 1);
        send(4'd13, 1'b0, 4'd3, 1'b0, acc);
        check("pp_lvl2", Level, 1);
        send(4'd13, 1'b0, 4'd0, 1'b0, acc);
        check("pp_lvl3", Level, 1);
        send(4'd15, 1'b0, 4'd2, 1'b0, acc);
        check("pp_lvl4", Level, 1);
        cyc();
        check("pp_drain", Level, 0);

        // sync
        send(4'd9, 1'b0, 4'd10, 1'b1, acc);
        send(4'd5, 1'b1, 4'd5, 1'b0, acc);
        Sync = 1'b1;
        cyc();
        Sync = 1'b0;
        send(4'd6, 1'b0, 4'd6, 1'b0, acc);
        cyc();
        check("sync_drain", Level, 0);

        // async reset with FIFO full
        OutReady = 1'b0;
        send(4'd3, 1'b0, 4'd13, 1'b1, acc);
        send(4'd4, 1'b0, 4'd1, 1'b0, acc);
        check("ar_full", Level, 2);
        #2;
        Reset = 1'b0;
        q.delete();
        #1;
        check("ar_valid", OutValid, 0);
        check("ar_level", Level, 0);
        check("ar_ready", InReady, 1);
        check("ar_data", OutData, 0);
        @(negedge Clock);
        Reset = 1'b1;
        OutReady = 1'b1;
        send(4'd4, 1'b0, 4'd4, 1'b0, acc);
        check("ar_post_valid", OutValid, 1);
        check("ar_post_data", OutData, 4);
        cyc();
        check("end_level", Level, 0);
        check("end_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
